reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 175 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer with an in-order commit FSM that emits a one-cycle register-file strobe.
// Optional build macro ROB_X0_FILTER_EN suppresses the write strobe for entries whose dest is register 0.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAGW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            allocValid,
  input  logic [4:0]      allocDest,
  input  logic [2:0]      allocType,
  output logic            allocReady,
  output logic [TAGW-1:0] allocTag,
  input  logic            completeValid,
  input  logic [TAGW-1:0] completeTag,
  input  logic [31:0]     completeData,
  input  logic            flush,
  output logic            ROBwriteEnable,
  output logic [31:0]     ROBwriteData,
  output logic [4:0]      ROBwriteIndex,
  output logic [2:0]      ROBwriteType,
  output logic [TAGW:0]   count
);

  typedef enum logic {IDLE, STROBE} state_e;

  localparam logic [TAGW:0] DEPTH_CNT = (TAGW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [TAGW-1:0]   head_q, head_d;
  logic [TAGW-1:0]   tail_q, tail_d;
  logic [TAGW:0]     count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [4:0]        dest_q [DEPTH];
  logic [4:0]        dest_d [DEPTH];
  logic [2:0]        type_q [DEPTH];
  logic [2:0]        type_d [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];

  logic              wen_q, wen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        widx_q, widx_d;
  logic [2:0]        wtype_q, wtype_d;

  logic              alloc_fire;
  logic              comp_fire;
  logic              comp_head;
  logic              head_done;
  logic [31:0]       head_data;
  logic              commit;
  logic              wr_ok;

  assign allocReady     = (count_q < DEPTH_CNT);
  assign allocTag       = tail_q;
  assign count          = count_q;
  assign ROBwriteEnable = wen_q;
  assign ROBwriteData   = wdata_q;
  assign ROBwriteIndex  = widx_q;
  assign ROBwriteType   = wtype_q;

`ifdef ROB_X0_FILTER_EN
  assign wr_ok = (dest_q[head_q] != 5'd0);
`else
  assign wr_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    dest_d  = dest_q;
    type_d  = type_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    widx_d  = widx_q;
    wtype_d = wtype_q;

    alloc_fire = allocValid && allocReady && !flush;
    comp_fire  = completeValid && valid_q[completeTag] && !flush
                 && !(alloc_fire && (completeTag == tail_q));
    // A completion landing on the head this cycle is forwarded so it commits next cycle.
    comp_head  = comp_fire && (completeTag == head_q);
    head_done  = done_q[head_q] || comp_head;
    head_data  = comp_head ? completeData : data_q[head_q];
    commit     = (state_q == IDLE) && valid_q[head_q] && head_done && !flush;

    if (comp_fire) begin
      done_d[completeTag] = 1'b1;
      data_d[completeTag] = completeData;
    end

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      dest_d[tail_q]  = allocDest;
      type_d[tail_q]  = allocType;
      tail_d          = tail_q + 1'b1;
    end

    // Commit stage: IDLE launches the strobe, STROBE forces the mandatory low cycle.
    case (state_q)
      IDLE: begin
        if (commit) begin
          valid_d[head_q] = 1'b0;
          done_d[head_q]  = 1'b0;
          head_d          = head_q + 1'b1;
          state_d         = STROBE;
          if (wr_ok) begin
            wen_d   = 1'b1;
            wdata_d = head_data;
            widx_d  = dest_q[head_q];
            wtype_d = type_q[head_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case ({alloc_fire, commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = IDLE;
      wen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      widx_q  <= '0;
      wtype_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      widx_q  <= widx_d;
      wtype_q <= wtype_d;
    end
  end

  // Entry payload is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    type_q <= type_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer checked against a queue-based model of in-order commit.
module tb_reorder_buffer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        allocValid = 1'b0;
  logic [4:0]  allocDest = '0;
  logic [2:0]  allocType = '0;
  logic        allocReady;
  logic [2:0]  allocTag;
  logic        completeValid = 1'b0;
  logic [2:0]  completeTag = '0;
  logic [31:0] completeData = '0;
  logic        flush = 1'b0;
  logic        ROBwriteEnable;
  logic [31:0] ROBwriteData;
  logic [4:0]  ROBwriteIndex;
  logic [2:0]  ROBwriteType;
  logic [3:0]  count;

  reorder_buffer #(.DEPTH(DEPTH), .TAGW(3)) dut (
    .clk(clk), .rst(rst),
    .allocValid(allocValid), .allocDest(allocDest), .allocType(allocType),
    .allocReady(allocReady), .allocTag(allocTag),
    .completeValid(completeValid), .completeTag(completeTag), .completeData(completeData),
    .flush(flush),
    .ROBwriteEnable(ROBwriteEnable), .ROBwriteData(ROBwriteData),
    .ROBwriteIndex(ROBwriteIndex), .ROBwriteType(ROBwriteType),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [2:0]  typ;
    logic [31:0] data;
    bit          done;
  } ent_t;

  ent_t        q[$];
  int          m_head = 0;
  int          m_tail = 0;
  bit          cool = 0;
  bit          model_ok = 0;
  bit          m_en = 0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_idx = '0;
  logic [2:0]  m_type = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference: queue holds live entries oldest first; cool marks the low cycle after a commit.
  task automatic model_step(input bit r, input bit av, input logic [4:0] ad, input logic [2:0] at,
                            input bit cv, input logic [2:0] ct, input logic [31:0] cd, input bit fl);
    bit   acc;
    int   p;
    bit   wr;
    ent_t e;
    if (r) begin
      q.delete(); m_head = 0; m_tail = 0; cool = 0;
      m_en = 0; m_data = '0; m_idx = '0; m_type = '0; model_ok = 1;
    end else if (fl) begin
      q.delete(); m_head = 0; m_tail = 0; cool = 0; m_en = 0;
    end else begin
      acc = av && (q.size() < DEPTH);
      p = (int'(ct) - m_head + DEPTH) % DEPTH;
      if (cv && p < q.size()) begin
        q[p].done = 1;
        q[p].data = cd;
      end
      m_en = 0;
      if (cool) cool = 0;
      else if (q.size() > 0 && q[0].done) begin
        e = q.pop_front();
        m_head = (m_head + 1) % DEPTH;
        cool = 1;
        wr = 1;
`ifdef ROB_X0_FILTER_EN
        wr = (e.dest != 5'd0);
`endif
        if (wr) begin
          m_en = 1; m_data = e.data; m_idx = e.dest; m_type = e.typ;
        end
      end
      if (acc) begin
        e.dest = ad; e.typ = at; e.data = '0; e.done = 0;
        q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit av, input logic [4:0] ad, input logic [2:0] at,
                     input bit cv, input logic [2:0] ct, input logic [31:0] cd, input bit fl);
    @(negedge clk);
    if (model_ok) begin
      chk("wen",   32'(ROBwriteEnable), 32'(m_en));
      chk("wdata", ROBwriteData,        m_data);
      chk("widx",  32'(ROBwriteIndex),  32'(m_idx));
      chk("wtype", 32'(ROBwriteType),   32'(m_type));
      chk("ready", 32'(allocReady),     32'(q.size() < DEPTH));
      chk("tag",   32'(allocTag),       32'(m_tail));
      chk("count", 32'(count),          32'(q.size()));
    end
    rst = r; allocValid = av; allocDest = ad; allocType = at;
    completeValid = cv; completeTag = ct; completeData = cd; flush = fl;
    @(posedge clk);
    model_step(r, av, ad, at, cv, ct, cd, fl);
  endtask

  task automatic idle();
    cyc(0, 0, 5'd0, 3'd0, 0, 3'd0, 32'd0, 0);
  endtask
  task automatic alloc(input logic [4:0] d, input logic [2:0] t);
    cyc(0, 1, d, t, 0, 3'd0, 32'd0, 0);
  endtask
  task automatic comp(input logic [2:0] t, input logic [31:0] d);
    cyc(0, 0, 5'd0, 3'd0, 1, t, d, 0);
  endtask
  task automatic do_rst();
    cyc(1, 0, 5'd0, 3'd0, 0, 3'd0, 32'd0, 0);
  endtask
  task automatic do_flush();
    cyc(0, 0, 5'd0, 3'd0, 0, 3'd0, 32'd0, 1);
  endtask

  initial begin
    // Single commit with forwarding latency.
    do_rst();
    #1;
    chk("rst_wen", 32'(ROBwriteEnable), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_rdy", 32'(allocReady), 32'd1);
    chk("rst_tag", 32'(allocTag), 32'd0);
    alloc(5'd5, 3'b010);
    comp(3'd0, 32'hDEADBEEF);
    #1;
    chk("c1_wen",  32'(ROBwriteEnable), 32'd1);
    chk("c1_idx",  32'(ROBwriteIndex), 32'd5);
    chk("c1_data", ROBwriteData, 32'hDEADBEEF);
    chk("c1_type", 32'(ROBwriteType), 32'd2);
    idle();
    #1;
    chk("c1_low", 32'(ROBwriteEnable), 32'd0);
    chk("c1_cnt", 32'(count), 32'd0);

    // Out-of-order completion, in-order commit two cycles apart.
    do_rst();
    alloc(5'd7, 3'd1); alloc(5'd8, 3'd2); alloc(5'd9, 3'd3);
    comp(3'd2, 32'h22); comp(3'd1, 32'h11);
    #1;
    chk("ooo_wait", 32'(ROBwriteEnable), 32'd0);
    comp(3'd0, 32'h00);
    #1;
    chk("ooo_c0", 32'(ROBwriteIndex), 32'd7);
    idle();
    #1;
    chk("ooo_gap", 32'(ROBwriteEnable), 32'd0);
    idle();
    #1;
    chk("ooo_c1", 32'(ROBwriteIndex), 32'd8);
    chk("ooo_e1", 32'(ROBwriteEnable), 32'd1);
    repeat (3) idle();
    #1;
    chk("ooo_c2", 32'(ROBwriteIndex), 32'd9);

    // Full buffer, held allocation, wrap of tail.
    do_rst();
    for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1), 3'd2);
    #1;
    chk("full_cnt", 32'(count), 32'd8);
    chk("full_rdy", 32'(allocReady), 32'd0);
    alloc(5'd20, 3'd2);
    #1;
    chk("full_hold", 32'(count), 32'd8);
    cyc(0, 1, 5'd20, 3'd2, 1, 3'd0, 32'h55, 0);
    #1;
    chk("full_wen", 32'(ROBwriteEnable), 32'd1);
    chk("full_tag", 32'(allocTag), 32'd0);
    chk("full_rdy2", 32'(allocReady), 32'd1);
    alloc(5'd20, 3'd2);
    #1;
    chk("full_acc", 32'(count), 32'd8);
    do_flush();

    // Completion to an invalid tag, then flush with a done entry.
    alloc(5'd3, 3'd0); alloc(5'd4, 3'd0);
    comp(3'd4, 32'h44);
    #1;
    chk("inv_cnt", 32'(count), 32'd2);
    chk("inv_wen", 32'(ROBwriteEnable), 32'd0);
    alloc(5'd6, 3'd0);
    comp(3'd1, 32'h99);
    do_flush();
    #1;
    chk("fl_cnt", 32'(count), 32'd0);
    repeat (3) idle();
    #1;
    chk("fl_wen", 32'(ROBwriteEnable), 32'd0);

    // Reset in the middle of a strobe.
    alloc(5'd12, 3'd5);
    comp(3'd0, 32'hCAFE);
    #1;
    chk("strb_wen", 32'(ROBwriteEnable), 32'd1);
    do_rst();
    #1;
    chk("sr_wen",  32'(ROBwriteEnable), 32'd0);
    chk("sr_data", ROBwriteData, 32'd0);
    chk("sr_idx",  32'(ROBwriteIndex), 32'd0);
    chk("sr_type", 32'(ROBwriteType), 32'd0);
    chk("sr_cnt",  32'(count), 32'd0);

    // Destination register 0.
    alloc(5'd0, 3'd2);
    comp(3'd0, 32'h1);
    #1;
`ifdef ROB_X0_FILTER_EN
    chk("x0_wen", 32'(ROBwriteEnable), 32'd0);
`else
    chk("x0_wen", 32'(ROBwriteEnable), 32'd1);
    chk("x0_idx", 32'(ROBwriteIndex), 32'd0);
`endif
    chk("x0_cnt", 32'(count), 32'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 31)),
          3'($urandom_range(0, 7)),
          $urandom_range(0, 9) < 6,
          3'($urandom_range(0, 7)),
          $urandom,
          $urandom_range(0, 59) == 0);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
